cpu_ifetch: RTL and testbench
=============================

Name: cpu_ifetch

Overview:
- Instruction fetch stage (p1) of the Falcon pipeline. Sits directly upstream of the decode stage.
- Maintains the fetch PC and issues pipelined requests on the instruction-memory bus.
- Buffers returned words, with their PCs, in a small FIFO.
- Presents the FIFO head to decode as p2_instr/p2_pc/p2_instr_valid.
- On a taken jump from p3, redirects the fetch PC, flushes the FIFO and discards in-flight responses.

Parameters:
- RESET_PC, 32'hFFFF0000, address fetched first after reset.
- DEPTH, 4, FIFO entries; also the maximum of buffered plus outstanding requests (power of 2, ≥2).

Ports:
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- stall  in  1  global pipeline stall; p2 holds its output.
- p2_bubble  in  1  decode cannot accept this cycle; hold p2 output.
- p3_jump_taken  in  1  taken branch/jump resolved in p3.
- p3_jump_target  in  32  redirect address.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  word-aligned fetch address.
- imem_ready  in  1  bus accepts request this cycle.
- imem_rvalid  in  1  read data valid; responses are in order, ≥1 cycle after accept, no backpressure.
- imem_rdata  in  32  instruction word.
- p2_instr  out  32  instruction to decode; 0 when not valid.
- p2_pc  out  32  PC of p2_instr; 0 when not valid.
- p2_instr_valid  out  1  p2_instr/p2_pc hold a real instruction.

Behaviour:
- Reset state:
  - fetch_pc=RESET_PC, resp_pc=RESET_PC.
  - FIFO empty; outstanding=0; discard=0.
  - imem_req=0; p2_instr_valid=0; p2_instr=0; p2_pc=0.
  - Reset overrides all other inputs, including mid-transfer. Responses for requests accepted before reset are not discarded; the environment guarantees none are in flight across reset.
- Issue: imem_req=1 when !reset && !jump && (outstanding + count − pop) < DEPTH. imem_addr=fetch_pc.
- Accept: imem_req && imem_ready → fetch_pc += 4 (wraps at 2^32) and outstanding += 1.
  - req and addr may change while unaccepted; the bus has no hold requirement.
- Response, when imem_rvalid, outstanding −= 1:
  - discard>0: word dropped, discard −= 1.
  - discard=0: push {imem_rdata, resp_pc} into FIFO; resp_pc += 4.
  - Accept and response in the same cycle leave outstanding unchanged.
- Output: p2_instr_valid = FIFO non-empty; p2_instr/p2_pc = head entry, or 0 when empty.
  - Registered FIFO: a word arriving on cycle N is visible on cycle N+1.
- Pop: p2_instr_valid && !stall && !p2_bubble && !jump.
  - Push and pop in the same cycle: count unchanged.
  - Push always fits because of the issue rule.
- Jump, where jump = p3_jump_taken && !stall:
  - fetch_pc and resp_pc ← {p3_jump_target[31:2], 2'b00}.
  - FIFO flushed; no pop.
  - imem_req=0 that cycle.
  - discard ← outstanding, minus 1 if imem_rvalid that cycle, and counting any request-accept in that cycle; since req=0 during jump, that term is 0.
  - Issue from the new target starts the next cycle.
- p3_jump_taken while stall=1 is ignored; p3 re-presents it once the stall clears.
- stall=1 otherwise: fetch issue and response capture continue, since the buffer has room; only pop is suppressed.
- Throughput: 1-cycle-latency, always-ready memory sustains one instruction per cycle with DEPTH ≥ 2.
- Jump penalty, same memory: target issued on cycle J+1, returns on J+2, valid at p2 on J+3.

Test Plan:
- Release reset with 1-cycle memory, imem_ready=1:
  - imem_addr sequence FFFF0000, FFFF0004, FFFF0008…
  - p2_pc=FFFF0000 valid 2 cycles after first accept.
  - Then one instruction per cycle with p2_instr = the stored words.
- Hold p2_bubble=1 for 6 cycles:
  - p2_instr/p2_pc frozen at the same entry.
  - imem_req drops once count+outstanding=DEPTH(4).
  - No word is lost or duplicated after release; PCs stay consecutive.
- Memory latency 3 cycles with 3 outstanding, then jump to 0x00001002:
  - The 3 late responses are dropped.
  - Next valid p2_pc=0x00001000 with the word from 0x00001000.
- Jump with imem_rvalid in the same cycle and outstanding=1: that response is dropped, discard=0 afterwards, and the next response is captured.
- p3_jump_taken=1 with stall=1: no redirect and no flush.
  - After stall clears, with jump still asserted, redirect occurs.
- imem_ready toggling 1,0,0,1 and reset asserted mid-stream:
  - Addresses are never skipped.
  - Reset returns all outputs to 0/idle next cycle and restarts at FFFF0000.

Source files
------------

// File: rtl/cpu_ifetch.sv
// rtl/cpu_ifetch.sv - Falcon p1 instruction fetch: PC, imem request issue, response FIFO to decode
module cpu_ifetch #(
  parameter logic [31:0] RESET_PC = 32'hFFFF0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        p2_bubble,
  input  logic        p3_jump_taken,
  input  logic [31:0] p3_jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] p2_instr,
  output logic [31:0] p2_pc,
  output logic        p2_instr_valid
);

  // Pointer width indexes DEPTH entries; counters need one more bit to hold DEPTH itself.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   fifo_instr [DEPTH];
  logic [31:0]   fifo_pc    [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;

  logic          jump;
  logic          pop;
  logic          push;
  logic          drop;
  logic          accept;
  logic [CW:0]   occupancy;
  logic [31:0]   jump_pc;

  // The two low target bits are forced to zero for word alignment.
  logic          unused_target_bits;
  assign unused_target_bits = ^p3_jump_target[1:0];

  // Control decode: jump qualification, pop, issue throttle and response routing.
  always_comb begin
    jump      = p3_jump_taken && !stall;
    jump_pc   = {p3_jump_target[31:2], 2'b00};
    pop       = (count != '0) && !stall && !p2_bubble && !jump;
    // Every accepted request must be guaranteed a FIFO slot when it returns,
    // so buffered plus in-flight words (after this cycle's pop) stay below DEPTH.
    occupancy = {1'b0, outstanding} + {1'b0, count} - {{CW{1'b0}}, pop};
    imem_req  = !reset && !jump && (occupancy < DEPTH_W);
    imem_addr = fetch_pc;
    accept    = imem_req && imem_ready;
    // Words still owed from before a redirect are thrown away; during the jump
    // cycle itself the FIFO is flushed, so a returning word is not captured.
    drop      = imem_rvalid && (discard != '0);
    push      = imem_rvalid && (discard == '0) && !jump;
  end

  // Decode-facing outputs come straight from the registered FIFO head.
  always_comb begin
    p2_instr_valid = (count != '0);
    p2_instr       = '0;
    p2_pc          = '0;
    if (count != '0) begin
      p2_instr = fifo_instr[rd_ptr];
      p2_pc    = fifo_pc[rd_ptr];
    end
  end

  // FIFO storage: written on capture, contents qualified by count so no reset needed.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      fifo_instr[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]    <= resp_pc;
    end
  end

  // Fetch PC: advances on each accepted request, reloads on a redirect.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
    end else if (jump) begin
      fetch_pc <= jump_pc;
    end else if (accept) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // Response PC: tags each captured word, restarting at the redirect target.
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_pc <= RESET_PC;
    end else if (jump) begin
      resp_pc <= jump_pc;
    end else if (push) begin
      resp_pc <= resp_pc + 32'd4;
    end
  end

  // In-flight request count: +1 on accept, -1 on each returned word.
  always_ff @(posedge clock) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(imem_rvalid);
    end
  end

  // Discard count: on a redirect every request still owed after this cycle is stale.
  always_ff @(posedge clock) begin
    if (reset) begin
      discard <= '0;
    end else if (jump) begin
      discard <= outstanding + CW'(accept) - CW'(imem_rvalid);
    end else if (drop) begin
      discard <= discard - CW'(1);
    end
  end

  // FIFO pointers and occupancy, flushed wholesale on a redirect.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (jump) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_cpu_ifetch.sv
// tb/tb_cpu_ifetch.sv - directed vector bench for cpu_ifetch
module tb_cpu_ifetch;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        p2_bubble = 1'b0;
  logic        p3_jump_taken = 1'b0;
  logic [31:0] p3_jump_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] p2_instr;
  logic [31:0] p2_pc;
  logic        p2_instr_valid;

  cpu_ifetch #(.RESET_PC(32'hFFFF0000), .DEPTH(4)) dut (
    .clock(clock), .reset(reset), .stall(stall), .p2_bubble(p2_bubble),
    .p3_jump_taken(p3_jump_taken), .p3_jump_target(p3_jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .p2_instr(p2_instr), .p2_pc(p2_pc), .p2_instr_valid(p2_instr_valid)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;
  int last_due = -1;
  logic [31:0] q_addr [$];
  int          q_due  [$];

  typedef struct {
    logic        bubble;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t vt [17];

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A5AC3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_p2(input string name, input logic v, input logic [31:0] pc);
    chk({name, "_valid"}, {31'h0, p2_instr_valid}, {31'h0, v});
    chk({name, "_pc"}, p2_pc, v ? pc : 32'h0);
    chk({name, "_instr"}, p2_instr, v ? word(pc) : 32'h0);
  endtask

  // Memory model: deliver due response, settle, then record any accept.
  task automatic prep();
    int d;
    if (q_due.size() > 0 && q_due[0] == cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word(q_addr[0]);
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEADBEEF;
    end
    #1;
    if (imem_req && imem_ready) begin
      d = cyc + lat;
      if (d <= last_due) d = last_due + 1;
      q_addr.push_back(imem_addr);
      q_due.push_back(d);
      last_due = d;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    cyc++;
  endtask

  task automatic do_reset();
    q_addr.delete();
    q_due.delete();
    last_due = -1;
    reset = 1'b1; stall = 1'b0; p2_bubble = 1'b0; p3_jump_taken = 1'b0; imem_ready = 1'b1;
    prep();
    chk("reset_req", {31'h0, imem_req}, 32'h0);
    tick();
    prep();
    tick();
    reset = 1'b0;
    q_addr.delete();
    q_due.delete();
  endtask

  initial begin
    vt[0]  = '{1'b0, 1'b1, 32'hFFFF0000, 1'b0, 32'h0};
    vt[1]  = '{1'b0, 1'b1, 32'hFFFF0004, 1'b0, 32'h0};
    vt[2]  = '{1'b0, 1'b1, 32'hFFFF0008, 1'b1, 32'hFFFF0000};
    vt[3]  = '{1'b0, 1'b1, 32'hFFFF000C, 1'b1, 32'hFFFF0004};
    vt[4]  = '{1'b0, 1'b1, 32'hFFFF0010, 1'b1, 32'hFFFF0008};
    vt[5]  = '{1'b0, 1'b1, 32'hFFFF0014, 1'b1, 32'hFFFF000C};
    vt[6]  = '{1'b1, 1'b1, 32'hFFFF0018, 1'b1, 32'hFFFF0010};
    vt[7]  = '{1'b1, 1'b1, 32'hFFFF001C, 1'b1, 32'hFFFF0010};
    vt[8]  = '{1'b1, 1'b0, 32'hFFFF0020, 1'b1, 32'hFFFF0010};
    vt[9]  = '{1'b1, 1'b0, 32'hFFFF0020, 1'b1, 32'hFFFF0010};
    vt[10] = '{1'b1, 1'b0, 32'hFFFF0020, 1'b1, 32'hFFFF0010};
    vt[11] = '{1'b1, 1'b0, 32'hFFFF0020, 1'b1, 32'hFFFF0010};
    vt[12] = '{1'b0, 1'b1, 32'hFFFF0020, 1'b1, 32'hFFFF0010};
    vt[13] = '{1'b0, 1'b1, 32'hFFFF0024, 1'b1, 32'hFFFF0014};
    vt[14] = '{1'b0, 1'b1, 32'hFFFF0028, 1'b1, 32'hFFFF0018};
    vt[15] = '{1'b0, 1'b1, 32'hFFFF002C, 1'b1, 32'hFFFF001C};
    vt[16] = '{1'b0, 1'b1, 32'hFFFF0030, 1'b1, 32'hFFFF0020};

    @(negedge clock);

    // Streaming after reset, then 6-cycle bubble hold and release.
    do_reset();
    lat = 1;
    for (int i = 0; i < 17; i++) begin
      p2_bubble = vt[i].bubble;
      prep();
      chk($sformatf("vec%0d_req", i), {31'h0, imem_req}, {31'h0, vt[i].exp_req});
      chk($sformatf("vec%0d_addr", i), imem_addr, vt[i].exp_addr);
      chk_p2($sformatf("vec%0d", i), vt[i].exp_valid, vt[i].exp_pc);
      tick();
    end
    p2_bubble = 1'b0;

    // 3-cycle memory, 3 outstanding, jump to unaligned 0x1002.
    do_reset();
    lat = 3;
    prep(); tick();
    prep(); tick();
    prep(); tick();
    p3_jump_taken = 1'b1; p3_jump_target = 32'h00001002;
    prep();
    chk("jA_req_off", {31'h0, imem_req}, 32'h0);
    tick();
    p3_jump_taken = 1'b0;
    prep();
    chk("jA_addr", imem_addr, 32'h00001000);
    chk_p2("jA_c4", 1'b0, 32'h0);
    tick();
    prep(); chk_p2("jA_c5", 1'b0, 32'h0); tick();
    prep(); chk_p2("jA_c6", 1'b0, 32'h0); tick();
    prep(); chk_p2("jA_c7", 1'b0, 32'h0); tick();
    prep(); chk_p2("jA_c8", 1'b1, 32'h00001000); tick();
    prep(); chk_p2("jA_c9", 1'b1, 32'h00001004); tick();

    // Jump coinciding with the only outstanding response.
    do_reset();
    lat = 1;
    prep(); tick();
    p3_jump_taken = 1'b1; p3_jump_target = 32'h00002000;
    prep();
    chk("jB_req_off", {31'h0, imem_req}, 32'h0);
    tick();
    p3_jump_taken = 1'b0;
    prep();
    chk("jB_addr", imem_addr, 32'h00002000);
    chk_p2("jB_c2", 1'b0, 32'h0);
    tick();
    prep(); chk_p2("jB_c3", 1'b0, 32'h0); tick();
    prep(); chk_p2("jB_c4", 1'b1, 32'h00002000); tick();
    prep(); chk_p2("jB_c5", 1'b1, 32'h00002004); tick();

    // Jump held during stall is ignored, then taken when the stall clears.
    do_reset();
    lat = 1;
    for (int i = 0; i < 4; i++) begin
      prep(); tick();
    end
    stall = 1'b1; p3_jump_taken = 1'b1; p3_jump_target = 32'h00003000;
    prep();
    chk("jC_c4_addr", imem_addr, 32'hFFFF0010);
    chk_p2("jC_c4", 1'b1, 32'hFFFF0008);
    tick();
    prep();
    chk("jC_c5_addr", imem_addr, 32'hFFFF0014);
    chk_p2("jC_c5", 1'b1, 32'hFFFF0008);
    tick();
    stall = 1'b0;
    prep();
    chk("jC_c6_req_off", {31'h0, imem_req}, 32'h0);
    chk_p2("jC_c6", 1'b1, 32'hFFFF0008);
    tick();
    p3_jump_taken = 1'b0;
    prep();
    chk("jC_c7_addr", imem_addr, 32'h00003000);
    chk_p2("jC_c7", 1'b0, 32'h0);
    tick();
    prep(); chk_p2("jC_c8", 1'b0, 32'h0); tick();
    prep(); chk_p2("jC_c9", 1'b1, 32'h00003000); tick();

    // imem_ready 1,0,0,1 then reset mid-stream.
    do_reset();
    lat = 1;
    imem_ready = 1'b1; prep(); chk("rd_c0_addr", imem_addr, 32'hFFFF0000); tick();
    imem_ready = 1'b0; prep(); chk("rd_c1_addr", imem_addr, 32'hFFFF0004); tick();
    imem_ready = 1'b0; prep(); chk("rd_c2_addr", imem_addr, 32'hFFFF0004);
    chk_p2("rd_c2", 1'b1, 32'hFFFF0000); tick();
    imem_ready = 1'b1; prep(); chk("rd_c3_addr", imem_addr, 32'hFFFF0004);
    chk_p2("rd_c3", 1'b0, 32'h0); tick();
    prep(); chk("rd_c4_addr", imem_addr, 32'hFFFF0008); tick();
    reset = 1'b1;
    prep();
    chk("rd_c5_req_rst", {31'h0, imem_req}, 32'h0);
    chk_p2("rd_c5", 1'b1, 32'hFFFF0004);
    tick();
    reset = 1'b0;
    q_addr.delete();
    q_due.delete();
    last_due = -1;
    prep();
    chk("rd_post_req", {31'h0, imem_req}, 32'h1);
    chk("rd_post_addr", imem_addr, 32'hFFFF0000);
    chk_p2("rd_post", 1'b0, 32'h0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
